// File: rtl/data_packing.sv
// Posit encoder: packs sign/regime/exponent/fraction fields into an N-bit posit
// with round-to-nearest-even, through a two-stage valid/ready pipeline.
module data_packing #(
  parameter int N  = 8,
  parameter int ES = 4,
  parameter int RS = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 Sign,
  input  logic signed [RS+1:0] RegimeValue,
  input  logic [ES-1:0]        Exponent,
  input  logic [N-3-ES:0]      Mantissa,
  input  logic                 zero,
  input  logic                 inf,
  output logic [N-1:0]         Out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W = 2 * N;

  logic         ld1, ld2;
  logic         v1_q, v2_q;
  logic         sign1_q, zero1_q, inf1_q;
  logic [W-1:0] tail_w, str_d, str_q;
  logic [N-1:0] out_d, out_q;
  logic [N-2:0] mag, mag_r;
  logic [N-1:0] rnd_sum, pos;
  logic         guard, sticky, rnd_up;
  int           k_s1;

  assign ld2       = !v2_q || out_ready;
  assign ld1       = !v1_q || ld2;
  assign in_ready  = !rst_n || ld1;
  assign out_valid = v2_q;
  assign Out       = out_q;

  assign tail_w = {Exponent, Mantissa, {(W-N+2){1'b0}}};

  // Saturated regimes are folded into a string that rounds to maxpos/minpos,
  // so stage 2 needs no separate saturation flags.
  always_comb begin
    k_s1  = int'(RegimeValue);
    str_d = '0;
    if (k_s1 > N - 2)
      str_d = {{(N-1){1'b1}}, {(W-N+1){1'b0}}};
    else if (k_s1 < -(N - 2))
      str_d = {{(N-2){1'b0}}, 1'b1, {(W-N+1){1'b0}}};
    else if (k_s1 >= 0)
      str_d = ~({W{1'b1}} >> (k_s1 + 1)) | (tail_w >> (k_s1 + 2));
    else
      str_d = {1'b1, tail_w[W-1:1]} >> (-k_s1);
  end

  always_comb begin
    mag     = str_q[W-1 -: N-1];
    guard   = str_q[W-N];
    sticky  = |str_q[W-N-1:0];
    rnd_up  = guard && (sticky || mag[0]);
    rnd_sum = {1'b0, mag} + {{(N-1){1'b0}}, rnd_up};
    mag_r   = rnd_sum[N-1] ? {(N-1){1'b1}} : rnd_sum[N-2:0];
    pos     = {1'b0, mag_r};
    out_d   = sign1_q ? -pos : pos;
    if (zero1_q) out_d = '0;
    if (inf1_q)  out_d = {1'b1, {(N-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      str_q   <= '0;
      sign1_q <= 1'b0;
      zero1_q <= 1'b0;
      inf1_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      if (ld1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          str_q   <= str_d;
          sign1_q <= Sign;
          zero1_q <= zero;
          inf1_q  <= inf;
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) out_q <= out_d;
      end
    end
  end

endmodule

// File: doc/data_packing.md
DATA_PACKING -- requirements
Module: data_packing

Interface
REQ-001 SHALL have parameter N, default 8, meaning posit word width in bits.
REQ-002 SHALL have parameter ES, default 4, meaning exponent field width in bits.
REQ-003 SHALL have parameter RS, default $clog2(N), meaning regime-count width base.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  input fields valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port Sign  input  1  sign of value (1 = negative).
REQ-009 SHALL have port RegimeValue  input  RS+2  signed regime k.
REQ-010 SHALL have port Exponent  input  ES  unsigned exponent field.
REQ-011 SHALL have port Mantissa  input  N-2-ES  fraction bits, hidden bit excluded, MSB first.
REQ-012 SHALL have port zero  input  1  value is zero; overrides the other fields.
REQ-013 SHALL have port inf  input  1  value is NaR; overrides zero and the other fields.
REQ-014 SHALL have port Out  output  N  encoded posit.
REQ-015 SHALL have port out_valid  output  1  Out is valid.
REQ-016 SHALL have port out_ready  input  1  consumer accepts Out this cycle.

Function
REQ-017 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-018 SHALL be a two-stage pipeline: stage 1 registers a regime-expanded bit string, and stage 2 registers the rounded, sign-applied Out.
REQ-019 SHALL have a latency of exactly 2 cycles from input transfer to out_valid when out_ready is held at 1, and SHALL sustain 1 transfer per cycle.
REQ-020 SHALL load stage 2 when !v2 || out_ready, and SHALL load stage 1 when !v1 || (stage-2 load).
REQ-021 SHALL drive in_ready = !v1 || (stage-2 load); a combinational path from out_ready to in_ready is permitted.
REQ-022 SHALL hold Out and out_valid stable while out_valid && !out_ready, with no data loss or duplication.
REQ-023 SHALL encode the regime as follows: for k>=0, k+1 ones then a 0; for k<0, -k zeros then a 1. It is followed by Exponent, then Mantissa, to form the magnitude string.
REQ-024 SHALL form the magnitude as the first N-1 bits of that string; guard = the next bit; sticky = OR of all remaining bits.
REQ-025 SHALL round to nearest even: increment the magnitude when guard && (sticky || magnitude LSB).
REQ-026 SHALL saturate as follows: k > N-2 gives magnitude maxpos (all N-1 bits 1); k < -(N-2) gives minpos (magnitude 1); a rounding carry beyond maxpos clamps to maxpos.
REQ-027 SHALL never produce a result of 0 or NaR from a nonzero finite input.
REQ-028 SHALL form Out = {0, magnitude} when Sign = 0, and the N-bit two's complement of {0, magnitude} when Sign = 1.
REQ-029 SHALL produce Out = 0 for zero = 1 (any Sign), and Out = 1 followed by N-1 zeros for inf = 1; inf takes priority when both are set.
REQ-030 SHALL ignore input fields when in_valid = 0 and SHALL change no state due to them.

Reset
REQ-031 SHALL, when rst_n = 0 at a rising edge, clear v1, v2 and out_valid to 0, and set Out to 0 and pipeline data registers to 0.
REQ-032 SHALL drive in_ready = 1 during and after reset.
REQ-033 SHALL discard any in-flight items on reset, including reset mid-stall; no output appears for them.
REQ-034 SHALL accept a new input on the first rising edge after rst_n returns to 1.

Verification (N=8, ES=4, Mantissa 2 bits, out_ready = 1 unless stated)
REQ-035 SHALL pass: Sign=0, k=0, E=0, M=00 -> Out=0x40 two cycles later; Sign=1, same fields -> 0xC0; k=-1, E=0xF, M=00 -> 0x3E.
REQ-036 SHALL pass a rounding check: k=0, E=0, M=11 (guard 1, LSB 1) -> 0x42; k=0, E=0, M=10 (guard 0) -> 0x41.
REQ-037 SHALL pass saturation and specials: k=7 -> 0x7F; Sign=1, k=7 -> 0x81; k=-7 -> 0x01; zero=1 -> 0x00; inf=1 with zero=1 -> 0x80.
REQ-038 SHALL pass a back-pressure check: hold out_ready=0 and stream 3 inputs; in_ready falls after 2 accepted; release out_ready; outputs appear in order with no loss or duplication.
REQ-039 SHALL pass a reset-mid-operation check: assert rst_n=0 with v1=v2=1; next cycle out_valid=0 and in_ready=1; no stale output after reset release.
REQ-040 SHALL pass a sweep: compare all RegimeValue in [-8,7] x Exponent x Mantissa x Sign against a reference encoder model, including decode-then-re-encode of all 256 8-bit posits returning the original word.
